// File: rtl/sr_driver_if.sv
// sr_driver_if: command handshake bundle for sr_driver (valid/ready, one op bit).
// Latency: none, pure wiring.
// Backpressure: cmd_ready from the slave gates acceptance; the master holds cmd_op while cmd_valid waits.
// Signals: cmd_valid (master->slave), cmd_op (1 = set, 0 = reset), cmd_ready (slave->master).
interface sr_driver_if;
  logic cmd_valid;
  logic cmd_op;
  logic cmd_ready;

  modport master (output cmd_valid, output cmd_op, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, output cmd_ready);
endinterface

// File: rtl/sr_driver.sv
// sr_driver: buffers set/reset commands and emits mutually exclusive s/r pulses, with optional q feedback check.
// Latency: a command accepted into an empty, idle block drives s/r from the next edge, for PULSE_W cycles.
// Backpressure: cmd_ready is low only while the FIFO holds DEPTH entries; it never depends on cmd_valid.
//
// Ports: clk, rstn (async active-low); cmd (sr_driver_if.slave: cmd_valid/cmd_op/cmd_ready);
//        s/r registered pulses; q_fb flop feedback; q_exp expected flop state; level FIFO occupancy;
//        busy (FSM active or FIFO non-empty); err sticky mismatch flag; err_clr synchronous clear.
// Option: define SR_DRIVER_CHECK_EN to build the feedback checker; otherwise err is tied 0.
module sr_driver #(
  parameter int PULSE_W = 1,
  parameter int GAP_W   = 1,
  parameter int DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  sr_driver_if.slave             cmd,
  output logic                   s,
  output logic                   r,
  input  logic                   q_fb,
  output logic                   q_exp,
  output logic [$clog2(DEPTH):0] level,
  output logic                   busy,
  output logic                   err,
  input  logic                   err_clr
);

  localparam int AW   = $clog2(DEPTH);
  localparam int LW   = AW + 1;
  localparam int CMAX = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
  localparam int CW   = $clog2(CMAX) + 1;

  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [CW-1:0] P_LAST   = CW'(PULSE_W - 1);
  localparam logic [CW-1:0] G_LAST   = CW'(GAP_W - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PULSE = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic             op_q;
  logic             push;
  logic             pop;

  // Ready comes from the registered level only, so a full FIFO refuses a push
  // even on the edge where the FSM pops.
  assign cmd.cmd_ready = (level != FULL_LVL);
  assign push          = cmd.cmd_valid && cmd.cmd_ready;
  assign pop           = (state == ST_IDLE) && (level != '0);
  assign busy          = (state != ST_IDLE) || (level != '0);

  // Storage needs no reset: occupancy is tracked by level and the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= cmd.cmd_op;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // s and r are only ever loaded together from op / ~op, or cleared together,
  // so they cannot be high at the same time.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
      cnt   <= '0;
      op_q  <= 1'b0;
      s     <= 1'b0;
      r     <= 1'b0;
      q_exp <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            op_q  <= mem[rd_ptr];
            s     <= mem[rd_ptr];
            r     <= ~mem[rd_ptr];
            cnt   <= '0;
            state <= ST_PULSE;
          end
        end
        ST_PULSE: begin
          if (cnt == P_LAST) begin
            s     <= 1'b0;
            r     <= 1'b0;
            q_exp <= op_q;
            cnt   <= '0;
            state <= ST_GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (cnt == G_LAST) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          s     <= 1'b0;
          r     <= 1'b0;
          cnt   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef SR_DRIVER_CHECK_EN
  // The flop has had one full cycle after the pulse to settle, so q_fb is
  // compared on the edge that closes the first GAP cycle.
  logic chk;
  assign chk = (state == ST_GAP) && (cnt == '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err <= 1'b0;
    end else if (chk && (q_fb != q_exp)) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end
`else
  logic unused_chk_inputs;
  assign unused_chk_inputs = q_fb ^ err_clr;
  assign err = 1'b0;
`endif

endmodule
